// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline requester A, buffered requester B with starvation relief.
// Optional hazard scoreboard is built when WB_ARB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              stall_a,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] q_addr_1,
    input  logic [ADDR_W-1:0] q_addr_2,
    output logic              q_busy_1,
    output logic              q_busy_2,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 2);
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] buf_addr [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt;

    logic              buf_empty;
    logic              push;
    logic              pop;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Handshake: B transfers when b_valid && b_ready. b_ready looks only at
    // the registered count, so a pop never opens a slot in the same cycle.
    assign buf_empty = (count == '0);
    assign b_ready   = (count < CNT_W'(BUF_DEPTH));
    assign push      = b_valid & b_ready;
    assign head_addr = buf_addr[rd_ptr];
    assign head_data = buf_data[rd_ptr];

    always_comb begin
        grant_a  = a_valid & ~stall_a;
        grant_b  = ~grant_a & ~buf_empty;
        win_addr = head_addr;
        win_data = head_data;
        if (grant_a) begin
            win_addr = a_addr;
            win_data = a_data;
        end
    end

    assign pop = grant_b;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= b_addr;
            buf_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The counter may pass STARVE_LIM by one while the stall is being
    // scheduled; the forced B grant in the stall cycle clears it again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_a    <= 1'b0;
        end else begin
            stall_a <= (starve_cnt == STV_W'(STARVE_LIM));
            if (buf_empty || grant_b) begin
                starve_cnt <= '0;
            end else if (grant_a) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    // Register 0 is hardwired: grants to it are consumed but never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write_en <= 1'b0;
            if ((grant_a || grant_b) && (win_addr != '0)) begin
                rf_write_en   <= 1'b1;
                rf_write_addr <= win_addr;
                rf_write_data <= win_data;
            end
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && (iss_addr != '0)) set_mask[iss_addr] = 1'b1;
        if (grant_b)                       clr_mask[head_addr] = 1'b1;
    end

    // Applying the set after the clear lets a same-cycle reissue win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign q_busy_1 = pending[q_addr_1];
    assign q_busy_2 = pending[q_addr_2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{iss_valid, iss_addr, q_addr_1, q_addr_2};
    assign q_busy_1 = 1'b0;
    assign q_busy_2 = 1'b0;
`endif

endmodule
